// File: rtl/thcattus_uart_pkg.sv
// thcattus_uart_pkg
// Shared definitions for the ThCattus UART transmitter and receiver:
// the receiver FSM state encoding, the 8N1 frame constants and the
// clocks-per-bit helper.
package thcattus_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Whole system-clock cycles per bit period (integer division).
  function automatic int unsigned cycle_per_baud(input int unsigned clock_freq,
                                                 input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/thcattus_sync2.sv
// thcattus_sync2
// Two-flop synchronizer for asynchronous inputs. Both stages load
// RESET_VALUE on reset.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   d    - asynchronous input [WIDTH-1:0]
//   q    - synchronized output [WIDTH-1:0]
module thcattus_sync2 #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/thcattus_uart_rx.sv
// thcattus_uart_rx
// 8N1 UART receiver (LSB first) that packs DATA_WIDTH bytes into one word,
// byte 0 in [7:0], and presents each word as an AXI-Stream beat.
// Optional feature macro: THCATTUS_UART_RX_TIMEOUT_EN -- discards a partial
// word after TIMEOUT_BITS idle bit-times.
// Ports:
//   axis_aclk    - clock
//   axis_areset  - synchronous, active-high reset
//   uart_rx      - asynchronous serial input, idle high
//   axis_tvalid  - output word valid
//   axis_tready  - downstream ready
//   axis_tdata   - received word [DATA_WIDTH*8-1:0]
//   frame_error  - one-cycle pulse: stop bit sampled low
//   overrun      - one-cycle pulse: word completed while output still held
module thcattus_uart_rx
  import thcattus_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned CLOCK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                    axis_aclk,
  input  logic                    axis_areset,
  input  logic                    uart_rx,
  output logic                    axis_tvalid,
  input  logic                    axis_tready,
  output logic [DATA_WIDTH*8-1:0] axis_tdata,
  output logic                    frame_error,
  output logic                    overrun
);

  localparam int unsigned CPB      = cycle_per_baud(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned BIDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [31:0] CNT_HALF = 32'(CPB / 2 - 1);
  localparam logic [31:0] CNT_FULL = 32'(CPB - 1);

  if (CPB < 4 || DATA_WIDTH < 1 || DATA_WIDTH > 16 || TIMEOUT_BITS < 1 ||
      STOP_BITS != 1) begin : g_bad_cfg
    $error("thcattus_uart_rx: unsupported parameter set");
  end

  logic                    rx_s;
  uart_state_t             state, state_next;
  logic [31:0]             cnt;
  logic [2:0]              bit_idx;
  logic [7:0]              shift;
  logic [BIDX_W-1:0]       byte_idx;
  logic [DATA_WIDTH*8-1:0] word;
  logic [DATA_WIDTH*8-1:0] merged;
  logic                    data_tick, stop_tick;
  logic                    good_byte, word_done;

  thcattus_sync2 #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk (axis_aclk),
    .rst (axis_areset),
    .d   (uart_rx),
    .q   (rx_s)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) state <= ST_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_tick  = 1'b0;
    stop_tick  = 1'b0;
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      // A start bit that is high again at mid-bit was a glitch.
      ST_START: if (cnt == CNT_HALF) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (cnt == CNT_FULL) begin
          data_tick = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) state_next = ST_STOP;
        end
      end
      // Return to IDLE at the mid-stop sample so back-to-back frames are caught.
      ST_STOP: begin
        if (cnt == CNT_FULL) begin
          stop_tick  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state_next != state || data_tick) cnt <= '0;
      else if (state != ST_IDLE)            cnt <= cnt + 32'd1;
      if (state == ST_START)  bit_idx <= '0;
      else if (data_tick)     bit_idx <= bit_idx + 3'd1;
      if (data_tick) shift <= {rx_s, shift[7:1]};
    end
  end

  assign good_byte = stop_tick && rx_s;
  assign word_done = good_byte && (byte_idx == BIDX_W'(DATA_WIDTH - 1));

  // Current partial word with the just-received byte inserted at byte_idx.
  always_comb begin
    merged = word;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (byte_idx == BIDX_W'(i)) merged[i*8 +: 8] = shift;
    end
  end

`ifdef THCATTUS_UART_RX_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_CYCLES = 32'(TIMEOUT_BITS * CPB);
  logic [31:0] idle_cnt;
  logic        timeout_hit;

  assign timeout_hit = (idle_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset || state != ST_IDLE || byte_idx == '0 || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end
`endif

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      byte_idx    <= '0;
      word        <= '0;
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= stop_tick && !rx_s;
      overrun     <= 1'b0;
      if (axis_tvalid && axis_tready) axis_tvalid <= 1'b0;
      if (good_byte) begin
        word <= merged;
        if (word_done) begin
          byte_idx <= '0;
          // A same-cycle handshake frees the slot for the new word.
          if (!axis_tvalid || axis_tready) begin
            axis_tdata  <= merged;
            axis_tvalid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
`ifdef THCATTUS_UART_RX_TIMEOUT_EN
      else if (timeout_hit) begin
        byte_idx <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_thcattus_uart_rx.sv
// tb_thcattus_uart_rx
// Directed bench for thcattus_uart_rx at 10 clocks per bit, 4-byte words.
module tb_thcattus_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        fe;
  logic        ov;

  int n_checks = 0;
  int n_errors = 0;
  int beats = 0, fe_cnt = 0, ov_cnt = 0;
  int b0, f0, o0;
  logic [31:0] last_data = '0;

  always #5 clk = ~clk;

  thcattus_uart_rx #(
    .DATA_WIDTH   (4),
    .CLOCK_FREQ   (1_000_000),
    .BAUD_RATE    (100_000),
    .TIMEOUT_BITS (20)
  ) dut (
    .axis_aclk   (clk),
    .axis_areset (rst),
    .uart_rx     (uart_rx),
    .axis_tvalid (tvalid),
    .axis_tready (tready),
    .axis_tdata  (tdata),
    .frame_error (fe),
    .overrun     (ov)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) begin
        beats++;
        last_data = tdata;
      end
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b0 = beats;
    f0 = fe_cnt;
    o0 = ov_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    uart_rx = stop;
    tick(10);
    uart_rx = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    uart_rx = 1'b1;
    tready  = 1'b1;
    tick(3);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_frame_error", 32'(fe), 32'd0);
    check("rst_overrun", 32'(ov), 32'd0);
    rst = 1'b0;
    tick(5);

    // Byte order
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    tick(20);
    check("order_beats", 32'(beats - b0), 32'd1);
    check("order_data", last_data, 32'h44332211);
    check("order_fe", 32'(fe_cnt - f0), 32'd0);
    check("order_ov", 32'(ov_cnt - o0), 32'd0);

    // Framing error: bad byte dropped, word index unchanged
    snap();
    send_byte(8'hA5, 1'b0);
    tick(20);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    tick(20);
    check("ferr_fe", 32'(fe_cnt - f0), 32'd1);
    check("ferr_beats", 32'(beats - b0), 32'd1);
    check("ferr_data", last_data, 32'h04030201);

    // Glitch on idle line
    snap();
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(30);
    check("glitch_beats", 32'(beats - b0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - f0), 32'd0);
    check("glitch_ov", 32'(ov_cnt - o0), 32'd0);

    // Backpressure and overrun
    snap();
    tready = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    tick(20);
    check("bp_tvalid", 32'(tvalid), 32'd1);
    check("bp_tdata", tdata, 32'h04030201);
    check("bp_ov", 32'(ov_cnt - o0), 32'd1);
    check("bp_beats_held", 32'(beats - b0), 32'd0);
    tready = 1'b1;
    tick(2);
    check("bp_beats", 32'(beats - b0), 32'd1);
    check("bp_data", last_data, 32'h04030201);
    check("bp_tvalid_clr", 32'(tvalid), 32'd0);
    tick(10);
    check("bp_one_beat", 32'(beats - b0), 32'd1);

    // Reset mid-frame during byte 2
    snap();
    send_byte(8'h55, 1'b1);
    uart_rx = 1'b0;
    tick(30);
    uart_rx = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_tvalid", 32'(tvalid), 32'd0);
    check("rst_mid_tdata", tdata, 32'h0);
    tick(30);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    tick(20);
    check("rst_mid_beats", 32'(beats - b0), 32'd1);
    check("rst_mid_data", last_data, 32'hEFBEADDE);

    // Partial word followed by a long idle gap
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    tick(250);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b1);
    tick(20);
    check("timeout_beats", 32'(beats - b0), 32'd1);
`ifdef THCATTUS_UART_RX_TIMEOUT_EN
    check("timeout_data", last_data, 32'h13121110);
`else
    check("timeout_data", last_data, 32'h11100201);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
